// File: rtl/router_pkg.sv
// Shared types and header layout for the router ingress path.
package router_pkg;

  localparam int DATA_W   = 8;
  localparam int NUM_DEST = 3;
  localparam int DEST_W   = 2;
  localparam int LEN_W    = 6;

  localparam int LEN_MSB  = 7;
  localparam int LEN_LSB  = 2;
  localparam int ADDR_MSB = 1;
  localparam int ADDR_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PAYLOAD,
    ST_PARITY,
    ST_CHECK,
    ST_DROP_PAY
  } state_t;

  function automatic logic addr_ok(
    input logic [DEST_W-1:0] a
  );
    return int'(a) < NUM_DEST;
  endfunction

endpackage

// File: rtl/router_hold_reg.sv
// Single-entry holding register between the ingress FSM and
// the destination FIFOs; the byte carries its own destination.
module router_hold_reg
  import router_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                load,
  input  logic [DATA_W-1:0]   din,
  input  logic [DEST_W-1:0]   dest,
  input  logic [NUM_DEST-1:0] fifo_full,
  output logic [DATA_W-1:0]   hold,
  output logic                hold_valid,
  output logic [NUM_DEST-1:0] write_en,
  output logic                busy
);

  logic [DEST_W-1:0] hold_dest;

  assign busy = hold_valid && fifo_full[hold_dest];

  always_comb begin
    write_en = '0;
    if (hold_valid && !fifo_full[hold_dest])
      write_en[hold_dest] = 1'b1;
  end

  // a refill on the same edge as a write keeps the entry valid
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hold       <= '0;
      hold_dest  <= '0;
      hold_valid <= 1'b0;
    end else if (load) begin
      hold       <= din;
      hold_dest  <= dest;
      hold_valid <= 1'b1;
    end else if (|write_en) begin
      hold_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/router_pkt_ingress.sv
// Router ingress: header decode, length/address/parity checks.
// Parity checking enabled by defining ROUTER_PARITY_CHECK_EN.
module router_pkt_ingress
  import router_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic [DATA_W-1:0]   data_in,
  input  logic                pkt_valid,
  input  logic [NUM_DEST-1:0] fifo_full,
  output logic [DATA_W-1:0]   wr_data,
  output logic [NUM_DEST-1:0] write_en,
  output logic                busy,
  output logic                error,
  output logic                pkt_done
);

  state_t            state;
  state_t            state_nx;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  count_q;
  logic [DEST_W-1:0] dest_q;
  logic [DEST_W-1:0] hold_dest;
  logic [LEN_W-1:0]  hdr_len;
  logic [DEST_W-1:0] hdr_addr;
  logic              hdr_ok;
  logic              last_pay;
  logic              accept;
  logic              load;
  logic              hold_valid;
  logic              hr_busy;
  logic              len_err;
  logic              addr_err;
  logic              par_err;

  assign hdr_len  = data_in[LEN_MSB:LEN_LSB];
  assign hdr_addr = data_in[ADDR_MSB:ADDR_LSB];
  assign hdr_ok   = addr_ok(hdr_addr);
  assign last_pay = (count_q + LEN_W'(1)) == len_q;

  assign hold_dest = (state == ST_IDLE) ? hdr_addr : dest_q;

  // dropped packets never stall the source
  assign busy = hold_valid && hr_busy
             && (state != ST_DROP_PAY);

  router_hold_reg u_hold (
    .clock      (clock),
    .reset      (reset),
    .load       (load),
    .din        (data_in),
    .dest       (hold_dest),
    .fifo_full  (fifo_full),
    .hold       (wr_data),
    .hold_valid (hold_valid),
    .write_en   (write_en),
    .busy       (hr_busy)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    load     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (pkt_valid && !busy) begin
          accept = 1'b1;
          if (hdr_ok) begin
            load     = 1'b1;
            state_nx = ST_PAYLOAD;
          end else begin
            state_nx = ST_DROP_PAY;
          end
        end
      end
      ST_PAYLOAD: begin
        if (!busy) begin
          accept = 1'b1;
          load   = 1'b1;
          if (!pkt_valid)    state_nx = ST_CHECK;
          else if (last_pay) state_nx = ST_PARITY;
        end
      end
      ST_PARITY: begin
        if (!busy) begin
          accept   = 1'b1;
          load     = 1'b1;
          state_nx = ST_CHECK;
        end
      end
      ST_CHECK: state_nx = ST_IDLE;
      ST_DROP_PAY: begin
        accept = 1'b1;
        if (!pkt_valid) state_nx = ST_CHECK;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      len_q    <= '0;
      count_q  <= '0;
      dest_q   <= '0;
      len_err  <= 1'b0;
      addr_err <= 1'b0;
    end else if (accept) begin
      if (state == ST_IDLE) begin
        len_q    <= hdr_len;
        dest_q   <= hdr_addr;
        count_q  <= '0;
        len_err  <= 1'b0;
        addr_err <= !hdr_ok;
      end
      if (state == ST_PAYLOAD) begin
        count_q <= count_q + LEN_W'(1);
        if (!pkt_valid) len_err <= 1'b1;
      end
      if (state == ST_PARITY && pkt_valid)
        len_err <= 1'b1;
    end
  end

`ifdef ROUTER_PARITY_CHECK_EN
  logic [DATA_W-1:0] xor_q;
  logic              par_byte;

  assign par_byte = accept
    && ((state == ST_PARITY)
     || (state == ST_PAYLOAD && !pkt_valid));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      xor_q   <= '0;
      par_err <= 1'b0;
    end else if (accept && state == ST_IDLE) begin
      xor_q   <= data_in;
      par_err <= 1'b0;
    end else if (par_byte) begin
      par_err <= xor_q != data_in;
    end else if (accept && state == ST_PAYLOAD) begin
      xor_q <= xor_q ^ data_in;
    end
  end
`else
  assign par_err = 1'b0;
`endif

  assign pkt_done = state == ST_CHECK;
  assign error    = (state == ST_CHECK)
                 && (len_err || addr_err || par_err);

endmodule
